// File: rtl/sram_1rw1r_wmask_freepdk45.sv
// rtl/sram_1rw1r_wmask_freepdk45.sv - 1RW+1R masked-write SRAM with post-reset clear; SRAM_BYPASS_EN selects merged collision reads
module sram_1rw1r_wmask_freepdk45 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_WMASKS = 4,
  parameter int VERBOSE    = 1
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  init_done
);

  localparam int LANE_W = DATA_WIDTH / NUM_WMASKS;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    clr_we_q;
  logic                    init_done_q;

  logic                    csb0_q;
  logic                    web0_q;
  logic [NUM_WMASKS-1:0]   wmask0_q;
  logic [ADDR_WIDTH-1:0]   addr0_q;
  logic [DATA_WIDTH-1:0]   din0_q;
  logic                    csb1_q;
  logic [ADDR_WIDTH-1:0]   addr1_q;

  // Read "in flight" markers: req toggles at posedge, ack follows at negedge.
  logic                    rd0_req_q;
  logic                    rd1_req_q;
  logic                    rd0_ack_q;
  logic                    rd1_ack_q;
  logic [DATA_WIDTH-1:0]   dout0_q;
  logic [DATA_WIDTH-1:0]   dout1_q;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    wr0;
  logic                    rd0;
  logic                    rd1;
  logic [DATA_WIDTH-1:0]   lane_bits;
  logic [DATA_WIDTH-1:0]   rd1_data;

  // Access trace is a simulation-only aid; the synthesizable body has no hook for it.
  if (VERBOSE != 0) begin : g_verbose
  end

  assign wr0 = !csb0_q && !web0_q;
  assign rd0 = !csb0_q &&  web0_q;
  assign rd1 = !csb1_q;

  // Expand per-lane write enables into a per-bit mask.
  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      lane_bits[i*LANE_W +: LANE_W] = {LANE_W{wmask0_q[i]}};
    end
  end

  // Port-1 read data, optionally forwarding the lanes port 0 writes this cycle.
  always_comb begin
`ifdef SRAM_BYPASS_EN
    if (wr0 && (addr1_q == addr0_q)) begin
      rd1_data = (mem[addr1_q] & ~lane_bits) | (din0_q & lane_bits);
    end else begin
      rd1_data = mem[addr1_q];
    end
`else
    rd1_data = mem[addr1_q];
`endif
  end

  // Clear/ready FSM and posedge input capture; chip selects are held off while clearing.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      clr_addr_q  <= '0;
      clr_we_q    <= 1'b0;
      init_done_q <= 1'b0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b0;
      wmask0_q    <= '0;
      addr0_q     <= '0;
      din0_q      <= '0;
      csb1_q      <= 1'b1;
      addr1_q     <= '0;
      rd0_req_q   <= 1'b0;
      rd1_req_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          csb0_q     <= 1'b1;
          csb1_q     <= 1'b1;
          clr_we_q   <= 1'b1;
          clr_addr_q <= clr_cnt_q;
          if (clr_cnt_q == CLR_LAST) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          clr_we_q <= 1'b0;
          csb0_q   <= csb0;
          web0_q   <= web0;
          wmask0_q <= wmask0;
          addr0_q  <= addr0;
          din0_q   <= din0;
          csb1_q   <= csb1;
          addr1_q  <= addr1;
          if (!csb0 && web0) rd0_req_q <= ~rd0_req_q;
          if (!csb1)         rd1_req_q <= ~rd1_req_q;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Negedge read data capture; reset between edges suppresses the update.
  always_ff @(negedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout0_q   <= '0;
      dout1_q   <= '0;
      rd0_ack_q <= 1'b0;
      rd1_ack_q <= 1'b0;
    end else begin
      rd0_ack_q <= rd0_req_q;
      rd1_ack_q <= rd1_req_q;
      if (rd0) dout0_q <= mem[addr0_q];
      if (rd1) dout1_q <= rd1_data;
    end
  end

  // Negedge array update: clear word during CLEAR, masked write in READY.
  always_ff @(negedge clk0) begin
    if (clr_we_q) begin
      mem[clr_addr_q] <= '0;
    end else if (wr0) begin
      mem[addr0_q] <= (mem[addr0_q] & ~lane_bits) | (din0_q & lane_bits);
    end
  end

  assign dout0     = (rd0_req_q != rd0_ack_q) ? {DATA_WIDTH{1'bx}} : dout0_q;
  assign dout1     = (rd1_req_q != rd1_ack_q) ? {DATA_WIDTH{1'bx}} : dout1_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask_freepdk45.sv
// tb/tb_sram_1rw1r_wmask_freepdk45.sv - vector table, random model compare and reset/clear sequences
module tb_sram_1rw1r_wmask_freepdk45;

  logic        clk0 = 1'b0;
  logic        rst0_n;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [6:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        csb1;
  logic [6:0]  addr1;
  logic [31:0] dout1;
  logic        init_done;

  always #5 clk0 = ~clk0;

  sram_1rw1r_wmask_freepdk45 dut (
    .clk0      (clk0),
    .rst0_n    (rst0_n),
    .csb0      (csb0),
    .web0      (web0),
    .wmask0    (wmask0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0),
    .csb1      (csb1),
    .addr1     (addr1),
    .dout1     (dout1),
    .init_done (init_done)
  );

`ifdef SRAM_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h11112222;
`else
  localparam logic [31:0] COLL_EXP = 32'h11111111;
`endif

  typedef struct {
    logic        c0;
    logic        w0;
    logic [3:0]  m;
    logic [6:0]  a0;
    logic [31:0] d;
    logic        c1;
    logic [6:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        vecs [12];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_mem [128];
  logic [31:0] m_d0;
  logic [31:0] m_d1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 32'h0;
    m_d0 = 32'h0;
    m_d1 = 32'h0;
  endtask

  // One access cycle; returns sampled just after the negedge, then updates the model.
  task automatic apply(input logic c0, input logic w0, input logic [3:0] m, input logic [6:0] a0,
                       input logic [31:0] d, input logic c1, input logic [6:0] a1);
    logic [31:0] r1;
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    @(posedge clk0);
    @(negedge clk0);
    #1;
    if (!c1) begin
      r1 = m_mem[a1];
`ifdef SRAM_BYPASS_EN
      if (!c0 && !w0 && a0 == a1)
        for (int i = 0; i < 4; i++) if (m[i]) r1[i*8 +: 8] = d[i*8 +: 8];
`endif
      m_d1 = r1;
    end
    if (!c0 && w0) m_d0 = m_mem[a0];
    if (!c0 && !w0)
      for (int i = 0; i < 4; i++) if (m[i]) m_mem[a0][i*8 +: 8] = d[i*8 +: 8];
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 1'b1, 4'h0, 7'd2,  32'h0,        1'b0, 7'd5,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, 7'd3,  32'hFFFFFFFF, 1'b1, 7'd0,  32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'h5, 7'd3,  32'h12345678, 1'b1, 7'd0,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 7'd3,  32'h0,        1'b1, 7'd0,  32'hFF34FF78, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 7'd10, 32'hA5A5A5A5, 1'b1, 7'd0,  32'hFF34FF78, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 7'd10, 32'h0,        1'b1, 7'd0,  32'hFF34FF78, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 4'h0, 7'd10, 32'h0,        1'b0, 7'd10, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 7'd0,  32'h0,        1'b1, 7'd0,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 1'b0, 4'hF, 7'd7,  32'h11111111, 1'b1, 7'd0,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 1'b0, 4'h3, 7'd7,  32'h22222222, 1'b0, 7'd7,  32'hA5A5A5A5, COLL_EXP};
    vecs[10] = '{1'b0, 1'b1, 4'h0, 7'd7,  32'h0,        1'b0, 7'd7,  32'h11112222, 32'h11112222};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 7'd2,  32'h0,        1'b1, 7'd0,  32'h0,        32'h11112222};

    rst0_n = 1'b0;
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 7'd0; din0 = 32'h0; csb1 = 1'b1; addr1 = 7'd0;
    @(negedge clk0);
    #1;
    chk("reset_dout0", dout0, 32'h0);
    chk("reset_dout1", dout1, 32'h0);
    chk("reset_init_done", {31'h0, init_done}, 32'h0);

    // Clear sequence with a port-0 write to addr 2 held on the inputs throughout.
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 7'd2; din0 = 32'hCAFEF00D;
    rst0_n = 1'b1;
    for (int p = 1; p <= 128; p++) begin
      @(posedge clk0);
      #1;
      chk($sformatf("clear_init_done_p%0d", p), {31'h0, init_done}, (p >= 128) ? 32'h1 : 32'h0);
    end
    csb0 = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].c0, vecs[i].w0, vecs[i].m, vecs[i].a0, vecs[i].d, vecs[i].c1, vecs[i].a1);
      chk($sformatf("vec%0d_dout0", i), dout0, vecs[i].e0);
      chk($sformatf("vec%0d_dout1", i), dout1, vecs[i].e1);
    end

    for (int i = 0; i < 250; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            7'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)));
      chk($sformatf("rand%0d_dout0", i), dout0, m_d0);
      chk($sformatf("rand%0d_dout1", i), dout1, m_d1);
    end

    // Reset between the posedge and negedge of a write.
    apply(1'b0, 1'b1, 4'h0, 7'd10, 32'h0, 1'b0, 7'd10);
    chk("pre_rst_dout0", dout0, 32'hA5A5A5A5);
    chk("pre_rst_dout1", dout1, 32'hA5A5A5A5);
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 7'd1; din0 = 32'hDEADBEEF; csb1 = 1'b1;
    @(posedge clk0);
    #2;
    rst0_n = 1'b0;
    #1;
    chk("midrst_dout0", dout0, 32'h0);
    chk("midrst_dout1", dout1, 32'h0);
    chk("midrst_init_done", {31'h0, init_done}, 32'h0);
    csb0 = 1'b1;
    @(negedge clk0);
    #1;
    rst0_n = 1'b1;
    n = 0;
    while (!init_done && n < 300) begin
      @(posedge clk0);
      #1;
      n++;
    end
    chk("clear_length", 32'(n), 32'd128);
    model_reset();
    apply(1'b0, 1'b1, 4'h0, 7'd1, 32'h0, 1'b0, 7'd1);
    chk("post_rst_addr1_dout0", dout0, 32'h0);
    chk("post_rst_addr1_dout1", dout1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
